divide: RTL and testbench

DIVIDE -- requirements
Module: divide

---
 rtl/divide_if.sv | 20 ++
 rtl/divide.sv | 91 +++++++++
 tb/tb_divide.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/divide_if.sv
// Bus bundle for the divide block.
// Handshake: the master raises start (with A and B valid) as a level request;
// the divider accepts on a rising edge while idle. ok (or err) is a registered
// level that rises when Q and R are valid and stays set until the next accept.
// A held-high start is never taken as a second request: start must drop
// before a new operation can be accepted.
interface divide_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             ok;
    logic             err;

    modport master (output start, A, B, input Q, R, ok, err);
    modport slave  (input start, A, B, output Q, R, ok, err);
endinterface

// File: rtl/divide.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
// Optional feature macro: DIVIDE_ZERO_CHECK_EN -- when defined, a zero
// divisor bypasses the iteration loop and reports err instead of ok.
// Result latency: ok rises WIDTH+1 edges after the accepting edge.
module divide #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    divide_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] quo;    // dividend shifts out MSB first, quotient shifts in
    logic [WIDTH:0]   rem;    // one extra bit so the trial compare never overflows
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial;
    logic             fits;

    assign dbg_state = state;

    // Trial step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial = {rem[WIDTH-1:0], quo[WIDTH-1]};
        fits  = (trial >= {1'b0, b_reg});
    end

    // Control FSM and datapath; Q and R only move on entry to DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            b_reg   <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            bus.Q   <= '0;
            bus.R   <= '0;
            bus.ok  <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        b_reg   <= bus.B;
                        quo     <= bus.A;
                        rem     <= '0;
                        cnt     <= '0;
                        bus.ok  <= 1'b0;
                        bus.err <= 1'b0;
`ifdef DIVIDE_ZERO_CHECK_EN
                        if (bus.B == '0) begin
                            bus.err <= 1'b1;
                            bus.Q   <= '1;
                            bus.R   <= bus.A;
                            state   <= DONE;
                        end else begin
                            state   <= BUSY;
                        end
`else
                        state   <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (cnt == CW'(WIDTH)) begin
                        bus.Q  <= quo;
                        bus.R  <= rem[WIDTH-1:0];
                        bus.ok <= 1'b1;
                        state  <= DONE;
                    end else begin
                        rem <= fits ? (trial - {1'b0, b_reg}) : trial;
                        quo <= {quo[WIDTH-2:0], fits};
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divide.sv
// Self-checking bench for the divide block (WIDTH=8).
module tb_divide;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         total;
    int         bad;
    logic [7:0] prev_q;
    logic [7:0] prev_r;
    logic [15:0] exp_q[$];

    divide_if #(.WIDTH(8)) bus ();

    divide #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and tick helper.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer division, zero divisor gives all ones / A.
    function automatic logic [7:0] model_q(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return 8'hFF;
        return a / b;
    endfunction

    function automatic logic [7:0] model_r(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return a;
        return a % b;
    endfunction

    // Run one operation; hold keeps start high for extra cycles after the result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [15:0] e;
        int          n;
        int          lat;
        logic        zero;
`ifdef DIVIDE_ZERO_CHECK_EN
        zero = (b == 8'd0);
`else
        zero = 1'b0;
`endif
        lat = zero ? 0 : 9;
        exp_q.push_back({model_q(a, b), model_r(a, b)});
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        tick();
        if (!zero) begin
            check("acc_ok", 32'(bus.ok), 0);
            check("acc_err", 32'(bus.err), 0);
            check("acc_state", 32'(dbg_state), 32'(S_BUSY));
        end
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
        n = 0;
        while (bus.ok !== 1'b1 && bus.err !== 1'b1 && n < 20) begin
            check("hold_q", 32'(bus.Q), 32'(prev_q));
            check("hold_r", 32'(bus.R), 32'(prev_r));
            tick();
            n++;
        end
        check("latency", n, lat);
        e = exp_q.pop_front();
        check("res_q", 32'(bus.Q), 32'(e[15:8]));
        check("res_r", 32'(bus.R), 32'(e[7:0]));
        check("res_ok", 32'(bus.ok), 32'(!zero));
        check("res_err", 32'(bus.err), 32'(zero));
        if (b != 8'd0) begin
            check("ident", 32'(bus.Q) * 32'(b) + 32'(bus.R), 32'(a));
            check("r_lt_b", 32'(bus.R < b), 1);
        end
        prev_q = e[15:8];
        prev_r = e[7:0];
        for (int i = 0; i < hold; i++) begin
            tick();
            check("stable_q", 32'(bus.Q), 32'(prev_q));
            check("stable_r", 32'(bus.R), 32'(prev_r));
            check("stable_ok", 32'(bus.ok), 32'(!zero));
            check("stable_st", 32'(dbg_state), 32'(S_DONE));
        end
        bus.start = 1'b0;
        tick();
        check("idle_st", 32'(dbg_state), 32'(S_IDLE));
        check("idle_ok", 32'(bus.ok), 32'(!zero));
        check("idle_q", 32'(bus.Q), 32'(prev_q));
    endtask

    // Directed sequence followed by the random sweep and the report.
    initial begin
        total = 0;
        bad = 0;
        prev_q = 8'd0;
        prev_r = 8'd0;
        reset = 1'b0;
        bus.start = 1'b1;
        bus.A = 8'd64;
        bus.B = 8'd10;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_q", 32'(bus.Q), 0);
            check("rst_r", 32'(bus.R), 0);
            check("rst_ok", 32'(bus.ok), 0);
            check("rst_err", 32'(bus.err), 0);
            check("rst_st", 32'(dbg_state), 32'(S_IDLE));
        end
        reset = 1'b1;

        run_op(8'd64, 8'd10, 6);
        run_op(8'd200, 8'd7, 0);
        run_op(8'd5, 8'd9, 0);
        run_op(8'd37, 8'd0, 2);

        // Abort in the middle of BUSY.
        bus.A = 8'd255;
        bus.B = 8'd3;
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort_q", 32'(bus.Q), 0);
        check("abort_r", 32'(bus.R), 0);
        check("abort_ok", 32'(bus.ok), 0);
        check("abort_err", 32'(bus.err), 0);
        check("abort_st", 32'(dbg_state), 32'(S_IDLE));
        prev_q = 8'd0;
        prev_r = 8'd0;
        reset = 1'b1;
        bus.start = 1'b0;
        tick();
        run_op(8'd255, 8'd3, 0);

        // Boundary cases.
        run_op(8'd0, 8'd5, 0);
        run_op(8'd77, 8'd1, 0);
        run_op(8'd3, 8'd200, 0);
        run_op(8'd99, 8'd99, 0);
        run_op(8'd255, 8'd255, 0);

        for (int i = 0; i < 500; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
